rx_serial_fsm: RTL and testbench
================================

RX_SERIAL_FSM -- requirements
Module: rx_serial_fsm

Interface
REQ-001 SHALL have parameter DBIT, default 8: data bits per frame.
REQ-002 SHALL have parameter SB_TICK, default 16: oversampling ticks in the stop bit (16 = 1 stop bit).
REQ-003 SHALL have parameter DVSR_W, default 11: width of the divisor input.
REQ-004 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port dvsr_i, input, DVSR_W: baud divisor; sample tick every dvsr_i+1 clocks.
REQ-007 SHALL have port rx_i, input, 1: serial line, idle high, LSB-first, 1 start bit, DBIT data bits, 1 stop bit.
REQ-008 SHALL have port data_o, output, DBIT: last received byte, held until the next frame completes.
REQ-009 SHALL have port done_o, output, 1: one-cycle pulse when a frame completes.
REQ-010 SHALL have port err_o, output, 1: framing error (stop bit sampled low), valid with done_o and held until the next done_o.

Function
REQ-011 SHALL pass rx_i through a 2-flop synchronizer (reset value 1); all FSM decisions use the synchronized value.
REQ-012 SHALL run a free-running tick counter 0..dvsr_i: tick=1 when count==dvsr_i, then count returns to 0; dvsr_i=0 gives a tick every cycle.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP with an oversample counter s_cnt (4 bit) and a bit counter n_cnt.
REQ-014 IDLE: on synchronized rx==0, go to START and clear s_cnt; the transition is independent of tick.
REQ-015 START: on tick with s_cnt==7 (mid start bit), go to DATA with s_cnt=0 and n_cnt=0 if rx==0, else go to IDLE (glitch reject, no done_o); other ticks increment s_cnt.
REQ-016 DATA: on tick with s_cnt==15, shift rx into the MSB of the shift register (right shift) and clear s_cnt; if n_cnt==DBIT-1 go to STOP, else increment n_cnt.
REQ-017 STOP: on tick with s_cnt==SB_TICK-1, go to IDLE, load data_o from the shift register, set err_o=~rx and pulse done_o.
REQ-018 done_o SHALL assert in the clock cycle after the final stop-bit tick edge, for exactly one cycle.
REQ-019 Back-to-back frames: a start edge in the first IDLE cycle after STOP SHALL be accepted with no lost frame.
REQ-020 Changes to dvsr_i mid-frame SHALL take effect at the next tick-counter comparison; no other guarantee.
REQ-021 An rx low level that persists in IDLE (break) SHALL produce repeated frames with err_o=1; this is not a lockup.

Reset
REQ-022 While rst_i=1: state=IDLE, s_cnt=0, n_cnt=0, tick counter=0, shift register=0, data_o=0, done_o=0, err_o=0, synchronizer=1.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no done_o; reception restarts on the first falling edge after release.

Structure
REQ-024 Package rx_serial_pkg SHALL hold the state enum type (IDLE, START, DATA, STOP) and the constants OVS=16 and MID_START=7.
REQ-025 Tick generation SHALL be the sub-module baud_gen (inputs clk_i, rst_i, dvsr_i; output tick_o), shared with the transmitter.

Verification
REQ-026 dvsr_i=6 (bit = 112 clocks), send 0x55 with valid stop -> data_o=0x55, err_o=0, single-cycle done_o.
REQ-027 dvsr_i=6, frames 0x00 then 0xFF back-to-back -> two done_o pulses, data_o 0x00 then 0xFF, err_o=0 both.
REQ-028 Frame 0xA3 with stop bit driven low -> data_o=0xA3, err_o=1.
REQ-029 rx_i low for 3 ticks (21 clocks at dvsr_i=6) then high -> FSM returns to IDLE, no done_o.
REQ-030 rst_i pulsed during data bit 4 of a frame -> no done_o; the next clean frame 0x3C is received correctly.
REQ-031 dvsr_i=0, send 0xC9 -> data_o=0xC9 after 160 clocks of frame, err_o=0.

Source files
------------

// File: rtl/rx_serial_pkg.sv
// rx_serial_pkg: shared receiver state type and oversampling constants
package rx_serial_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
    localparam int OVS       = 16;
    localparam int MID_START = 7;
endpackage

// File: rtl/baud_gen.sv
// baud_gen: free-running sample tick, one pulse every dvsr_i+1 clocks
module baud_gen #(
    parameter int DVSR_W = 11
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DVSR_W-1:0] dvsr_i,
    output logic              tick_o
);
    logic [DVSR_W-1:0] cnt_q, cnt_d;
    assign tick_o = cnt_q >= dvsr_i;
    assign cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk_i)
        cnt_q <= rst_i ? '0 : cnt_d;
endmodule

// File: rtl/rx_serial_fsm.sv
// rx_serial_fsm: 16x oversampled UART receiver, LSB-first, one start and one stop bit
module rx_serial_fsm
    import rx_serial_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR_W  = 11
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DVSR_W-1:0] dvsr_i,
    input  logic              rx_i,
    output logic [DBIT-1:0]   data_o,
    output logic              done_o,
    output logic              err_o
);
    localparam int NW = DBIT > 1 ? $clog2(DBIT) : 1;
    state_e          state_q, state_d;
    logic [3:0]      s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d, data_q, data_d;
    logic            err_q, err_d, done_q, done_d;
    logic [1:0]      sync_q;
    logic            rx, tick;
    assign rx     = sync_q[1];
    assign data_o = data_q;
    assign done_o = done_q;
    assign err_o  = err_q;
    baud_gen #(.DVSR_W(DVSR_W)) u_baud (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .dvsr_i(dvsr_i),
        .tick_o(tick)
    );
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        data_d  = data_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (!rx) begin
                state_d = START;
                s_d     = '0;
            end
            START: if (tick) begin
                if (s_q == 4'(MID_START)) begin
                    state_d = rx ? IDLE : DATA;
                    s_d     = '0;
                    n_d     = '0;
                end else
                    s_d = s_q + 1'b1;
            end
            DATA: if (tick) begin
                if (s_q == 4'(OVS - 1)) begin
                    b_d     = DBIT'({rx, b_q} >> 1);
                    s_d     = '0;
                    state_d = n_q == NW'(DBIT - 1) ? STOP : DATA;
                    n_d     = n_q == NW'(DBIT - 1) ? n_q : n_q + 1'b1;
                end else
                    s_d = s_q + 1'b1;
            end
            STOP: if (tick) begin
                if (s_q == 4'(SB_TICK - 1)) begin
                    state_d = IDLE;
                    data_d  = b_q;
                    err_d   = ~rx;
                    done_d  = 1'b1;
                end else
                    s_d = s_q + 1'b1;
            end
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            sync_q  <= 2'b11;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            data_q  <= data_d;
            err_q   <= err_d;
            done_q  <= done_d;
            sync_q  <= {sync_q[0], rx_i};
        end
    end
endmodule

// File: tb/tb_rx_serial_fsm.sv
// tb_rx_serial_fsm: directed frames with hand-computed expected bytes and error flags
module tb_rx_serial_fsm;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] dvsr = 11'd6;
    logic        rx = 1'b1;
    logic [7:0]  data;
    logic        done, err;
    int          checks = 0, errors = 0;
    int          cyc = 0, wide = 0, first_done_cyc = -1;
    logic        prev_done = 1'b0;
    logic [8:0]  evq[$];

    rx_serial_fsm dut (
        .clk_i (clk),
        .rst_i (rst),
        .dvsr_i(dvsr),
        .rx_i  (rx),
        .data_o(data),
        .done_o(done),
        .err_o (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (done) begin
            evq.push_back({err, data});
            if (first_done_cyc < 0) first_done_cyc = cyc;
            if (prev_done) wide++;
        end
        prev_done = done;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] ev(input int i);
        return (i < evq.size()) ? evq[i] : 9'bx;
    endfunction

    task automatic bit_period(input logic v);
        rx = v;
        repeat (16 * (int'(dvsr) + 1)) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic stop_b);
        bit_period(1'b0);
        for (int i = 0; i < 8; i++) bit_period(d[i]);
        bit_period(stop_b);
        rx = 1'b1;
    endtask

    task automatic idle(input int bits);
        repeat (bits) bit_period(1'b1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_data", 32'(data), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        // single frame, valid stop
        send(8'h55, 1'b1);
        idle(1);
        chk("f55_count", evq.size(), 1);
        chk("f55_event", 32'(ev(0)), 32'h055);
        chk("f55_pulse_width", wide, 0);
        chk("f55_data_held", 32'(data), 32'h55);
        chk("f55_err_held", 32'(err), 32'h0);
        evq.delete();
        // back-to-back frames
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        idle(1);
        chk("b2b_count", evq.size(), 2);
        chk("b2b_first", 32'(ev(0)), 32'h000);
        chk("b2b_second", 32'(ev(1)), 32'h0FF);
        evq.delete();
        // framing error; the low stop bit may also start a follow-on frame
        send(8'hA3, 1'b0);
        chk("ferr_event", 32'(ev(0)), 32'h1A3);
        idle(12);
        evq.delete();
        // short glitch on the line
        rx = 1'b0;
        repeat (21) @(negedge clk);
        rx = 1'b1;
        idle(2);
        chk("glitch_no_done", evq.size(), 0);
        // reset during data bit 4 of 0x5A
        bit_period(1'b0);
        for (int i = 0; i < 4; i++) bit_period(1'(8'h5A >> i));
        rx = 1'b1;
        repeat (56) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_data", 32'(data), 32'h0);
        chk("midrst_err", 32'(err), 32'h0);
        chk("midrst_done", 32'(done), 32'h0);
        rst = 1'b0;
        idle(12);
        chk("midrst_no_done", evq.size(), 0);
        send(8'h3C, 1'b1);
        idle(1);
        chk("after_rst_count", evq.size(), 1);
        chk("after_rst_event", 32'(ev(0)), 32'h03C);
        evq.delete();
        // fastest divisor: one tick per clock, 160-clock frame
        rst = 1'b1;
        dvsr = 11'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        first_done_cyc = -1;
        begin
            int t0;
            t0 = cyc;
            send(8'hC9, 1'b1);
            idle(2);
            chk("fast_count", evq.size(), 1);
            chk("fast_event", 32'(ev(0)), 32'h0C9);
            chk("fast_within_frame", 32'(first_done_cyc > t0 && first_done_cyc - t0 <= 160), 32'h1);
        end
        chk("total_pulse_width", wide, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
